// File: rtl/banked_mem_pkg.sv
// Shared decode helpers and types for the banked read/write scratch memory.
// Address-to-bank/row mapping is kept here so the top and any checker agree.
package banked_mem_pkg;

  localparam int MAX_ADDR_W = 32;
  localparam int MAX_DATA_W = 64;

  typedef struct packed {
    logic                  we;
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0] wdata;
  } port_req_t;

  function automatic int addr_w_of(input int num_banks, input int bank_depth);
    if (num_banks * bank_depth > 32'sd1) begin
      return $clog2(num_banks * bank_depth);
    end else begin
      return 32'sd1;
    end
  endfunction

  function automatic int row_w_of(input int bank_depth);
    if (bank_depth > 32'sd1) begin
      return $clog2(bank_depth);
    end else begin
      return 32'sd1;
    end
  endfunction

  function automatic int bank_of(input int addr, input int interleave,
                                 input int num_banks, input int bank_depth);
    if (interleave != 32'sd0) begin
      return addr % num_banks;
    end else begin
      return addr / bank_depth;
    end
  endfunction

  function automatic int row_of(input int addr, input int interleave,
                                input int num_banks, input int bank_depth);
    if (interleave != 32'sd0) begin
      return addr / num_banks;
    end else begin
      return addr % bank_depth;
    end
  endfunction

endpackage

// File: rtl/banked_mem_rw_rr_arbiter.sv
// Round-robin arbiter for one bank: one-hot grant, searching upward from the
// stored pointer; the pointer moves to one past the winner.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] ptr_next_s;
  logic [PTR_W-1:0] sel_s;
  logic [N-1:0]     gnt_s;
  logic             found_s;
  int               idx_v;

  // Pick the first requester at or after the pointer, wrapping modulo N.
  always_comb begin
    gnt_s      = '0;
    found_s    = 1'b0;
    ptr_next_s = ptr_r;
    idx_v      = 32'sd0;
    sel_s      = '0;
    for (int k = 0; k < N; k++) begin
      idx_v = int'(ptr_r) + k;
      if (idx_v >= N) begin
        idx_v = idx_v - N;
      end else begin
        idx_v = idx_v;
      end
      sel_s = PTR_W'(idx_v);
      if (!found_s && !rst && req[sel_s]) begin
        gnt_s[sel_s] = 1'b1;
        found_s      = 1'b1;
        if (idx_v == N - 1) begin
          ptr_next_s = '0;
        end else begin
          ptr_next_s = PTR_W'(idx_v + 1);
        end
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else begin
      ptr_r <= ptr_next_s;
    end
  end

  assign gnt = gnt_s;

endmodule

// File: rtl/banked_mem_rw.sv
// Multi-port banked scratch memory with per-bank round-robin arbitration,
// same-cycle grants and a one-cycle registered read response path.
module banked_mem_rw
  import banked_mem_pkg::*;
#(
  parameter int NUM_BANKS  = 4,
  parameter int BANK_DEPTH = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_PORTS  = 4,
  parameter int INTERLEAVE = 1,
  parameter int ADDR_W     = addr_w_of(NUM_BANKS, BANK_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  output logic [NUM_PORTS-1:0]        gnt,
  output logic [NUM_PORTS-1:0]        rvalid,
  output logic [NUM_PORTS*DATA_W-1:0] rdata,
  output logic [NUM_PORTS-1:0]        err
);

  localparam int ROW_W  = row_w_of(BANK_DEPTH);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int TOTAL  = NUM_BANKS * BANK_DEPTH;

  int                   addr_v     [NUM_PORTS];
  logic [BANK_W-1:0]    bank_s     [NUM_PORTS];
  logic [ROW_W-1:0]     row_s      [NUM_PORTS];
  logic [NUM_PORTS-1:0] oor_s;
  logic [NUM_PORTS-1:0] bank_req_s [NUM_BANKS];
  logic [NUM_PORTS-1:0] bank_gnt_s [NUM_BANKS];
  logic [NUM_PORTS-1:0] gnt_s;

  logic [NUM_BANKS-1:0] wr_en_s;
  logic [ROW_W-1:0]     wr_row_s   [NUM_BANKS];
  logic [DATA_W-1:0]    wr_data_s  [NUM_BANKS];
  logic [DATA_W-1:0]    rd_word_s  [NUM_PORTS];

  logic [DATA_W-1:0]    mem_r      [NUM_BANKS][BANK_DEPTH];
  logic [NUM_PORTS-1:0]        rvalid_r;
  logic [NUM_PORTS-1:0]        err_r;
  logic [NUM_PORTS*DATA_W-1:0] rdata_r;

  // Per-port address decode; out-of-range ports decode to bank 0 row 0 but
  // never reach a bank because they are excluded from the request matrix.
  always_comb begin
    oor_s = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      addr_v[p] = int'(addr[p*ADDR_W +: ADDR_W]);
      oor_s[p]  = (addr_v[p] >= TOTAL);
      if (oor_s[p]) begin
        bank_s[p] = '0;
        row_s[p]  = '0;
      end else begin
        bank_s[p] = BANK_W'(bank_of(addr_v[p], INTERLEAVE, NUM_BANKS, BANK_DEPTH));
        row_s[p]  = ROW_W'(row_of(addr_v[p], INTERLEAVE, NUM_BANKS, BANK_DEPTH));
      end
    end
  end

  // Build the per-bank candidate matrix from in-range requests.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_req_s[b] = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        bank_req_s[b][p] = req[p] & ~oor_s[p] & ~rst & (int'(bank_s[p]) == b);
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    rr_arbiter #(
      .N(NUM_PORTS)
    ) u_arb (
      .clk(clk),
      .rst(rst),
      .req(bank_req_s[b]),
      .gnt(bank_gnt_s[b])
    );
  end

  // Out-of-range requests are granted directly without arbitration.
  always_comb begin
    gnt_s = req & oor_s & {NUM_PORTS{~rst}};
    for (int b = 0; b < NUM_BANKS; b++) begin
      gnt_s = gnt_s | bank_gnt_s[b];
    end
  end

  assign gnt = gnt_s;

  // Write mux: the bank grant is one-hot, so at most one port drives each bank.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      wr_en_s[b]   = 1'b0;
      wr_row_s[b]  = '0;
      wr_data_s[b] = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (bank_gnt_s[b][p] && we[p]) begin
          wr_en_s[b]   = 1'b1;
          wr_row_s[b]  = row_s[p];
          wr_data_s[b] = wdata[p*DATA_W +: DATA_W];
        end else begin
          wr_en_s[b] = wr_en_s[b];
        end
      end
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (wr_en_s[b]) begin
        mem_r[b][wr_row_s[b]] <= wr_data_s[b];
      end else begin
        mem_r[b][wr_row_s[b]] <= mem_r[b][wr_row_s[b]];
      end
    end
  end

  // Read port per requester, sampled only when that port is granted.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      rd_word_s[p] = mem_r[bank_s[p]][row_s[p]];
    end
  end

  // Response registers: rvalid pulses one cycle after each read or OOR grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_r <= '0;
      err_r    <= '0;
      rdata_r  <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (gnt_s[p] && oor_s[p]) begin
          rvalid_r[p]                 <= 1'b1;
          err_r[p]                    <= 1'b1;
          rdata_r[p*DATA_W +: DATA_W] <= '0;
        end else if (gnt_s[p] && !we[p]) begin
          rvalid_r[p]                 <= 1'b1;
          err_r[p]                    <= 1'b0;
          rdata_r[p*DATA_W +: DATA_W] <= rd_word_s[p];
        end else begin
          rvalid_r[p]                 <= 1'b0;
          err_r[p]                    <= 1'b0;
          rdata_r[p*DATA_W +: DATA_W] <= rdata_r[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign rvalid = rvalid_r;
  assign err    = err_r;
  assign rdata  = rdata_r;

endmodule
